fft_sdf_r2_stage: RTL and testbench

//  One radix-2 DIF single-delay-feedback FFT stage: butterfly, feedback delay line, twiddle multiply,

---
 rtl/fft_pkg.sv | 48 ++++
 rtl/fft_cmult_rs.sv | 78 +++++++
 rtl/fft_sdf_r2_stage.sv | 135 +++++++++++++
 tb/tb_fft_sdf_r2_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared helpers for the streaming FFT stages.
//   cplx_int_t     : integer complex pair used for elaboration-time constants
//   coeff_one()    : twiddle value representing 1.0 for a given coefficient width
//   twiddle()      : W_2L^n = (round(cos(pi*n/L)*ONE), round(-sin(pi*n/L)*ONE))
//   rnd_shr()      : round half-up, then arithmetic shift right
//   sat()          : clamp a value to a signed w-bit range
package fft_pkg;

   typedef struct packed {
      int re;
      int im;
   } cplx_int_t;

   function automatic int coeff_one(int nbits_coeff);
      return 1 << (nbits_coeff - 2);
   endfunction

   // Round to nearest, halves away from zero.
   function automatic int rnd_real(real v);
      if (v >= 0.0) return $rtoi($floor(v + 0.5));
      return -$rtoi($floor(-v + 0.5));
   endfunction

   // Elaboration-time only; never evaluated on live signals.
   function automatic cplx_int_t twiddle(int n, int log2l, int nbits_coeff);
      cplx_int_t w;
      real ang, one;
      one  = real'(coeff_one(nbits_coeff));
      ang  = 3.14159265358979323846 * real'(n) / real'(1 << log2l);
      w.re = rnd_real($cos(ang) * one);
      w.im = rnd_real(-$sin(ang) * one);
      return w;
   endfunction

   function automatic longint rnd_shr(longint v, int sh);
      return (v + (longint'(1) <<< (sh - 1))) >>> sh;
   endfunction

   function automatic longint sat(longint v, int w);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fft_cmult_rs.sv
// Two-stage complex multiply with round-half-up and saturation.
//   clk, rst          : clock, async active-low reset
//   vld_i, sof_i      : sideband tags travelling with the operands
//   a_re_i, a_im_i    : data operand (AW bits, signed)
//   c_re_i, c_im_i    : coefficient (CW bits, signed, 1.0 = 2^SH)
//   vld_o, sof_o      : tags, two cycles after vld_i
//   re_o, im_o        : rounded, saturated product (OW bits)
// Stage 1 registers the four partial products, stage 2 the combined result.
module fft_cmult_rs
   import fft_pkg::*;
#(
   parameter int AW = 11,
   parameter int CW = 11,
   parameter int OW = 15,
   parameter int SH = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vld_i,
   input  logic                 sof_i,
   input  logic signed [AW-1:0] a_re_i,
   input  logic signed [AW-1:0] a_im_i,
   input  logic signed [CW-1:0] c_re_i,
   input  logic signed [CW-1:0] c_im_i,
   output logic                 vld_o,
   output logic                 sof_o,
   output logic signed [OW-1:0] re_o,
   output logic signed [OW-1:0] im_o
);

   localparam int PW     = AW + CW;
   localparam int STAGES = 2;

   logic [STAGES:1] vld_pipe, sof_pipe;
   logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
   logic signed [OW-1:0] re_d, im_d;

   always_comb begin
      longint re_l, im_l;
      re_l = longint'(p_rr_q) - longint'(p_ii_q);
      im_l = longint'(p_ri_q) + longint'(p_ir_q);
      re_l = sat(rnd_shr(re_l, SH), OW);
      im_l = sat(rnd_shr(im_l, SH), OW);
      re_d = re_l[OW-1:0];
      im_d = im_l[OW-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         sof_pipe <= '0;
         p_rr_q   <= '0;
         p_ii_q   <= '0;
         p_ri_q   <= '0;
         p_ir_q   <= '0;
         re_o     <= '0;
         im_o     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], vld_i};
         sof_pipe <= {sof_pipe[STAGES-1:1], sof_i};
         // Data registers only load behind a valid tag; idle cycles leave them quiet.
         if (vld_i) begin
            p_rr_q <= PW'(a_re_i) * PW'(c_re_i);
            p_ii_q <= PW'(a_im_i) * PW'(c_im_i);
            p_ri_q <= PW'(a_re_i) * PW'(c_im_i);
            p_ir_q <= PW'(a_im_i) * PW'(c_re_i);
         end
         if (vld_pipe[1]) begin
            re_o <= re_d;
            im_o <= im_d;
         end
      end
   end

   assign vld_o = vld_pipe[STAGES];
   assign sof_o = sof_pipe[STAGES];

endmodule

// File: rtl/fft_sdf_r2_stage.sv
// Radix-2 DIF single-delay-feedback FFT stage.
//   clk, rst   : clock, async active-low reset
//   in_valid   : in_data / in_sof valid
//   in_sof     : first sample of an input frame (resyncs counter, clears primed)
//   in_data    : {re, im}, NBITS each
//   flush      : drain pending differences with no new input
//   out_valid  : out_data valid (accept pattern delayed 2 cycles)
//   out_sof    : first sample of an output frame
//   out_data   : {re, im}, NBITS_OUT each
// Output frame order: L sums, then the L twiddled differences, the latter
// emitted during the next frame's first half (or by flush).
module fft_sdf_r2_stage
   import fft_pkg::*;
#(
   parameter int NBITS       = 10,
   parameter int NBITS_COEFF = 11,
   parameter int NBITS_OUT   = 15,
   parameter int LOG2_DELAY  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_sof,
   input  logic [2*NBITS-1:0]     in_data,
   input  logic                   flush,
   output logic                   out_valid,
   output logic                   out_sof,
   output logic [2*NBITS_OUT-1:0] out_data
);

   localparam int L  = 1 << LOG2_DELAY;
   localparam int AW = NBITS + 1;
   localparam logic [LOG2_DELAY:0] CNT_ONE = 1;
   localparam logic signed [NBITS_COEFF-1:0] ONE = NBITS_COEFF'(coeff_one(NBITS_COEFF));

   logic [LOG2_DELAY:0]   cnt_q, cnt_d, cnt_eff;
   logic                  primed_q, primed_d, primed_eff;
   logic                  resync, phase, flush_acc, acc;
   logic [LOG2_DELAY-1:0] k;
   logic signed [AW-1:0]  x_re, x_im, dl_re, dl_im, a_re, a_im, wr_re, wr_im;
   logic signed [NBITS_COEFF-1:0] c_re, c_im;
   logic signed [NBITS_COEFF-1:0] tw_re [L];
   logic signed [NBITS_COEFF-1:0] tw_im [L];
   logic [2*AW-1:0]       dly_q [L];
   logic                  tag_vld, tag_sof;
   logic signed [NBITS_OUT-1:0] o_re, o_im;

   for (genvar n = 0; n < L; n++) begin : g_tw
      localparam cplx_int_t W = twiddle(n, LOG2_DELAY, NBITS_COEFF);
      assign tw_re[n] = NBITS_COEFF'(W.re);
      assign tw_im[n] = NBITS_COEFF'(W.im);
   end

   // A valid sof sample is forced to slot 0 of phase 0 and starts unprimed.
   assign resync     = in_valid & in_sof;
   assign cnt_eff    = resync ? '0 : cnt_q;
   assign primed_eff = resync ? 1'b0 : primed_q;
   assign phase      = cnt_eff[LOG2_DELAY];
   assign k          = cnt_eff[LOG2_DELAY-1:0];
   // Flush only advances the first half of a primed frame; input has priority.
   assign flush_acc  = flush & ~in_valid & primed_q & ~phase;
   assign acc        = in_valid | flush_acc;

   assign x_re  = in_valid ? AW'($signed(in_data[2*NBITS-1:NBITS])) : '0;
   assign x_im  = in_valid ? AW'($signed(in_data[NBITS-1:0]))       : '0;
   assign dl_re = $signed(dly_q[k][2*AW-1:AW]);
   assign dl_im = $signed(dly_q[k][AW-1:0]);

   always_comb begin
      a_re     = dl_re;
      a_im     = dl_im;
      c_re     = tw_re[k];
      c_im     = tw_im[k];
      wr_re    = x_re;
      wr_im    = x_im;
      tag_vld  = acc & primed_eff;
      tag_sof  = 1'b0;
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (phase) begin
         a_re    = dl_re + x_re;
         a_im    = dl_im + x_im;
         c_re    = ONE;
         c_im    = '0;
         wr_re   = dl_re - x_re;
         wr_im   = dl_im - x_im;
         tag_vld = acc;
         tag_sof = acc & (k == '0);
      end
      if (acc) begin
         cnt_d    = cnt_eff + CNT_ONE;
         primed_d = primed_eff | phase;
         // Last drained difference: park the stage so further flushes do nothing.
         if (flush_acc && (&k)) begin
            cnt_d    = '0;
            primed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         primed_q <= 1'b0;
         for (int i = 0; i < L; i++) dly_q[i] <= '0;
      end else begin
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
         if (acc) dly_q[k] <= {wr_re, wr_im};
      end
   end

   fft_cmult_rs #(
      .AW (AW),
      .CW (NBITS_COEFF),
      .OW (NBITS_OUT),
      .SH (NBITS_COEFF - 2)
   ) u_cmult (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (tag_vld),
      .sof_i  (tag_sof),
      .a_re_i (a_re),
      .a_im_i (a_im),
      .c_re_i (c_re),
      .c_im_i (c_im),
      .vld_o  (out_valid),
      .sof_o  (out_sof),
      .re_o   (o_re),
      .im_o   (o_im)
   );

   assign out_data = {o_re, o_im};

endmodule

// File: tb/tb_fft_sdf_r2_stage.sv
module tb_fft_sdf_r2_stage;

   localparam int NB    = 10;
   localparam int NBO   = 15;
   localparam int NBO_S = 11;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0, in_sof = 1'b0, flush = 1'b0;
   logic [2*NB-1:0]    in_data = '0;
   logic               out_valid, out_sof, out_valid_s, out_sof_s;
   logic [2*NBO-1:0]   out_data;
   logic [2*NBO_S-1:0] out_data_s;

   always #5 clk = ~clk;

   fft_sdf_r2_stage #(.NBITS(NB), .NBITS_COEFF(11), .NBITS_OUT(NBO), .LOG2_DELAY(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .flush(flush), .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data));

   // Same stream into a narrow-output instance to exercise saturation.
   fft_sdf_r2_stage #(.NBITS(NB), .NBITS_COEFF(11), .NBITS_OUT(NBO_S), .LOG2_DELAY(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .flush(flush), .out_valid(out_valid_s), .out_sof(out_sof_s), .out_data(out_data_s));

   typedef struct {
      bit v, sof, fl;
      int xr, xi;
      bit ev, esof;
      int er, ei;
   } vec_t;

   typedef struct {
      bit ev, esof;
      int er, ei;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(bit v, bit sof, bit fl, int xr, int xi,
                               bit ev, bit esof, int er, int ei);
      vec_t t;
      t = '{v, sof, fl, xr, xi, ev, esof, er, ei};
      vq.push_back(t);
   endfunction

   function automatic void zeros(int n, bit ev);
      for (int i = 0; i < n; i++) add(1, 0, 0, 0, 0, ev, 0, 0, 0);
   endfunction

   function automatic int sat11(int v);
      if (v > 1023)  return 1023;
      if (v < -1024) return -1024;
      return v;
   endfunction

   task automatic chk(input string nm, input logic signed [31:0] got, input int want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic sb_reset();
      exp_t idle;
      idle = '{0, 0, 0, 0};
      sb.delete();
      sb.push_back(idle);
   endtask

   // Drive one cycle; the output seen after this edge belongs to the previous accept cycle.
   task automatic step(input vec_t t);
      exp_t e;
      in_valid = t.v;
      in_sof   = t.sof;
      flush    = t.fl;
      in_data  = {NB'(t.xr), NB'(t.xi)};
      e = '{t.ev, t.esof, t.er, t.ei};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("out_valid", out_valid, e.ev);
      chk("out_valid_sat", out_valid_s, e.ev);
      if (e.ev) begin
         chk("out_sof", out_sof, e.esof);
         chk("out_re", $signed(out_data[2*NBO-1:NBO]), e.er);
         chk("out_im", $signed(out_data[NBO-1:0]), e.ei);
         chk("out_sof_sat", out_sof_s, e.esof);
         chk("out_re_sat", $signed(out_data_s[2*NBO_S-1:NBO_S]), sat11(e.er));
         chk("out_im_sat", $signed(out_data_s[NBO_S-1:0]), sat11(e.ei));
      end
   endtask

   task automatic run_vq();
      foreach (vq[i]) step(vq[i]);
      vq.delete();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_sof"}, out_sof, 0);
      chk({tag, "_out_data"}, $signed({2'b00, out_data}), 0);
      chk({tag, "_out_valid_sat"}, out_valid_s, 0);
      chk({tag, "_out_data_sat"}, $signed({2'b00, out_data_s}), 0);
   endtask

   initial begin
      #2 rst = 1'b0;
      #1 chk_reset_state("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      sb_reset();

      // ---- idle, plus a flush while unprimed (ignored)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      // ---- frame A: impulse at x0, resync
      add(1, 1, 0, 100, 0, 0, 0, 0, 0); zeros(3, 0);
      add(1, 0, 0, 0, 0, 1, 1, 100, 0); zeros(3, 1);
      // ---- frame B: x1 = (100,0); emits A's diffs then its sums
      add(1, 0, 0, 0, 0, 1, 0, 100, 0);
      add(1, 0, 0, 100, 0, 1, 0, 0, 0);
      zeros(2, 1);
      add(1, 0, 0, 0, 0, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 100, 0);
      zeros(2, 1);
      // ---- frame C: saturation pair; emits B's diff k=1 = W^1*(100,0)
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 511, 511, 1, 0, 71, -71);
      zeros(2, 1);
      add(1, 0, 0, 0, 0, 1, 1, 0, 0);
      add(1, 0, 0, -512, -512, 1, 0, -1, -1);
      zeros(2, 1);
      // ---- frame D: (50,-50) on alternate cycles; flush on phase-1 gaps is ignored,
      //      flush alongside a valid sample is overridden by the sample
      for (int j = 0; j < 8; j++) begin
         int er, ei;
         er = (j >= 4) ? 100 : ((j == 1) ? 1447 : 0);
         ei = (j >= 4) ? -100 : 0;
         add(1, 0, (j == 0), 50, -50, 1, (j == 4), er, ei);
         add(0, 0, (j >= 4 && j < 7), 0, 0, 0, 0, 0, 0);
      end
      // ---- frame E: impulse, no resync; emits D's zero diffs
      add(1, 0, 0, 100, 0, 1, 0, 0, 0); zeros(3, 1);
      add(1, 0, 0, 0, 0, 1, 1, 100, 0); zeros(3, 1);
      // ---- flush for 6 cycles: 4 diffs, then ignored
      add(0, 0, 1, 0, 0, 1, 0, 100, 0);
      for (int j = 0; j < 3; j++) add(0, 0, 1, 0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vq();

      // ---- reset in phase 1 while outputs are flowing
      add(1, 1, 0, 100, 0, 0, 0, 0, 0); zeros(3, 0);
      add(1, 0, 0, 0, 0, 1, 1, 100, 0); zeros(1, 1);
      run_vq();
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset_state("midreset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      sb_reset();

      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      // rerun impulse
      add(1, 1, 0, 100, 0, 0, 0, 0, 0); zeros(3, 0);
      add(1, 0, 0, 0, 0, 1, 1, 100, 0); zeros(3, 1);
      add(1, 0, 0, 0, 0, 1, 0, 100, 0); zeros(3, 1);
      add(1, 0, 0, 0, 0, 1, 1, 0, 0);   zeros(3, 1);
      // mid-frame resync: silent until the new frame's phase 1
      zeros(3, 1);
      add(1, 1, 0, 100, 0, 0, 0, 0, 0); zeros(3, 0);
      add(1, 0, 0, 0, 0, 1, 1, 100, 0); zeros(3, 1);
      add(0, 0, 1, 0, 0, 1, 0, 100, 0);
      for (int j = 0; j < 3; j++) add(0, 0, 1, 0, 0, 1, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vq();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
